// File: rtl/mem_lsu_pkg.sv
// Shared constants for the load/store unit: opcodes, func3 codes, FSM encodings
// and the access-size helper used by the lane logic.
package mem_lsu_pkg;

  localparam logic [6:0] INST_TYPE_L = 7'b0000011;
  localparam logic [6:0] INST_TYPE_S = 7'b0100011;

  localparam logic [2:0] INST_LB  = 3'b000;
  localparam logic [2:0] INST_LH  = 3'b001;
  localparam logic [2:0] INST_LW  = 3'b010;
  localparam logic [2:0] INST_LBU = 3'b100;
  localparam logic [2:0] INST_LHU = 3'b101;
  localparam logic [2:0] INST_SB  = 3'b000;
  localparam logic [2:0] INST_SH  = 3'b001;
  localparam logic [2:0] INST_SW  = 3'b010;

  localparam logic [1:0] LSU_IDLE = 2'd0;
  localparam logic [1:0] LSU_REQ  = 2'd1;
  localparam logic [1:0] LSU_WAIT = 2'd2;
  localparam logic [1:0] LSU_DONE = 2'd3;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_t;

  function automatic acc_size_t func3_size(input logic [2:0] func3);
    acc_size_t size;
    case (func3[1:0])
      2'b00:   size = SZ_BYTE;
      2'b01:   size = SZ_HALF;
      default: size = SZ_WORD;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane logic: legality, lane enables, store replication and load
// extraction/extension. Purely combinational.
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        legal
);

  acc_size_t          size;
  logic               func3_ok;
  logic               aligned;
  logic signed [7:0]  ld_byte;
  logic signed [15:0] ld_half;

  always_comb begin
    size = func3_size(func3);

    // Store codes SB/SH/SW share encodings with LB/LH/LW; there is no SBU/SHU.
    case (func3)
      INST_LB, INST_LH, INST_LW: func3_ok = 1'b1;
      INST_LBU, INST_LHU:        func3_ok = !we;
      default:                   func3_ok = 1'b0;
    endcase

    case (size)
      SZ_BYTE: aligned = 1'b1;
      SZ_HALF: aligned = !addr_lo[0];
      default: aligned = (addr_lo == 2'b00);
    endcase

    legal = func3_ok && aligned;

    ld_byte = rdata[{addr_lo, 3'b000} +: 8];
    ld_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      SZ_BYTE: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = func3[2] ? {24'b0, ld_byte} : 32'(ld_byte);
      end
      SZ_HALF: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = func3[2] ? {16'b0, ld_half} : 32'(ld_half);
      end
      default: begin
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: one req/gnt/rvalid data-bus access per instruction,
// with pipeline hold, load writeback and error pulse on illegal access or timeout.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ls_valid_i,
  input  logic        ls_we_i,
  input  logic [2:0]  ls_func3_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  input  logic [4:0]  rd_addr_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        rd_wen_o,
  output logic        hold_flag_o,
  output logic        err_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] cnt;
  logic             err_q;

  logic             we_q;
  logic [2:0]       func3_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [4:0]       rd_q;
  logic [31:0]      rdata_q;

  logic             in_idle;
  logic             in_req;
  logic             in_wait;
  logic             a_we;
  logic [2:0]       a_func3;
  logic [1:0]       a_addr_lo;
  logic [31:0]      a_wdata;
  logic [3:0]       be;
  logic [31:0]      wdata_lane;
  logic [31:0]      rdata_ext;
  logic             legal;
  logic             accept;
  logic             illegal;
  logic             timeout;
  logic             load_done;

  assign in_idle = (state == LSU_IDLE);
  assign in_req  = (state == LSU_REQ);
  assign in_wait = (state == LSU_WAIT);

  // In IDLE the lane logic judges the incoming instruction; afterwards it
  // works on the latched copy so bus fields stay stable until gnt.
  assign a_we      = in_idle ? ls_we_i          : we_q;
  assign a_func3   = in_idle ? ls_func3_i       : func3_q;
  assign a_addr_lo = in_idle ? ls_addr_i[1:0]   : addr_q[1:0];
  assign a_wdata   = in_idle ? ls_wdata_i       : wdata_q;

  mem_lsu_align u_align (
    .we         (a_we),
    .func3      (a_func3),
    .addr_lo    (a_addr_lo),
    .wdata      (a_wdata),
    .rdata      (mem_rdata_i),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext),
    .legal      (legal)
  );

  assign accept  = in_idle && ls_valid_i && legal;
  assign illegal = in_idle && ls_valid_i && !legal;
  // A grant or rvalid arriving on the last allowed cycle still completes.
  assign timeout = ((in_req && !mem_gnt_i) || (in_wait && !mem_rvalid_i)) &&
                   (cnt == CNT_LAST);

  always_comb begin
    state_next = state;
    case (state)
      LSU_IDLE: if (accept) state_next = LSU_REQ;
      LSU_REQ: begin
        if (mem_gnt_i)    state_next = we_q ? LSU_DONE : LSU_WAIT;
        else if (timeout) state_next = LSU_IDLE;
      end
      LSU_WAIT: begin
        if (mem_rvalid_i) state_next = LSU_DONE;
        else if (timeout) state_next = LSU_IDLE;
      end
      default:            state_next = LSU_IDLE;
    endcase
  end

  // Control stage: FSM, timeout counter, error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LSU_IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_next;
      err_q <= illegal || timeout;
      if (!in_idle && (state_next == LSU_REQ || state_next == LSU_WAIT))
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
    end
  end

  // Data stage: instruction fields at acceptance, load data at rvalid.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= ls_we_i;
      func3_q <= ls_func3_i;
      addr_q  <= ls_addr_i;
      wdata_q <= ls_wdata_i;
      rd_q    <= rd_addr_i;
    end
    if (in_wait && mem_rvalid_i)
      rdata_q <= rdata_ext;
  end

  assign load_done = (state == LSU_DONE) && !we_q;

  // Every output is gated by state so the unreset data registers never leak.
  assign mem_req_o   = in_req;
  assign mem_we_o    = in_req && we_q;
  assign mem_addr_o  = in_req ? {addr_q[31:2], 2'b00} : 32'b0;
  assign mem_be_o    = in_req ? be : 4'b0;
  assign mem_wdata_o = in_req ? wdata_lane : 32'b0;

  assign rd_wen_o    = load_done;
  assign rd_addr_o   = load_done ? rd_q : 5'b0;
  assign rd_data_o   = load_done ? rdata_q : 32'b0;

  assign hold_flag_o = rst_n && (accept || in_req || in_wait);
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: drivers push expected bus requests and
// writeback/error events; a monitor pops and compares them as the DUT emits.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ls_valid_i, ls_we_i;
  logic [2:0]  ls_func3_i;
  logic [31:0] ls_addr_i, ls_wdata_i;
  logic [4:0]  rd_addr_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        rd_wen_o, hold_flag_o, err_o;

  mem_lsu #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ls_valid_i(ls_valid_i), .ls_we_i(ls_we_i), .ls_func3_i(ls_func3_i),
    .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i), .rd_addr_i(rd_addr_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .rd_wen_o(rd_wen_o),
    .hold_flag_o(hold_flag_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } bus_t;

  typedef struct {
    logic        is_err;
    logic [4:0]  rd;
    logic [31:0] data;
  } ev_t;

  bus_t bus_q[$];
  ev_t  ev_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   req_total = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // Reference lane model written independently of the RTL decode.
  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] r;
    int n;
    n = 1 << f3[1:0];
    for (int i = 0; i < 4; i++) r[i] = (i >= int'(a)) && (i < int'(a) + n);
    return r;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = 1 << f3[1:0];
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] rd);
    logic [31:0] s, mask, r;
    int n;
    n = 1 << f3[1:0];
    s = rd >> (8 * int'(a));
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    r = s & mask;
    if (!f3[2] && n < 4 && s[8*n-1]) r = r | ~mask;
    return r;
  endfunction

  task automatic monitor();
    bus_t b;
    ev_t  e;
    forever begin
      @(negedge clk);
      if (mem_req_o) begin
        req_total++;
        check_eq("hold_in_req", 32'(hold_flag_o), 32'd1);
        if (mem_gnt_i) begin
          if (bus_q.size() == 0) check_eq("unexpected_req", 32'd1, 32'd0);
          else begin
            b = bus_q.pop_front();
            check_eq("bus_addr", mem_addr_o, b.addr);
            check_eq("bus_be", 32'(mem_be_o), 32'(b.be));
            check_eq("bus_we", 32'(mem_we_o), 32'(b.we));
            if (b.we) check_eq("bus_wdata", mem_wdata_o, b.wdata);
          end
        end
      end
      if (rd_wen_o || err_o) begin
        if (ev_q.size() == 0) check_eq("unexpected_event", 32'({rd_wen_o, err_o}), 32'd0);
        else begin
          e = ev_q.pop_front();
          check_eq("event_err", 32'(err_o), 32'(e.is_err));
          check_eq("event_wen", 32'(rd_wen_o), 32'(!e.is_err));
          if (!e.is_err) begin
            check_eq("wb_addr", 32'(rd_addr_o), 32'(e.rd));
            check_eq("wb_data", rd_data_o, e.data);
          end
        end
      end else begin
        check_eq("rd_addr_quiet", 32'(rd_addr_o), 32'd0);
        check_eq("rd_data_quiet", rd_data_o, 32'd0);
      end
    end
  endtask

  // gnt_dly < 0 means the bus never grants, so the access must time out.
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd, input int gnt_dly,
                        input logic [31:0] rdata, input int rv_dly, input logic [31:0] exp_data,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd);
    bus_t b;
    ev_t  e;
    int   r0, n;
    r0 = req_total;
    @(posedge clk); #1;
    ls_valid_i = 1'b1; ls_we_i = we; ls_func3_i = f3;
    ls_addr_i = addr; ls_wdata_i = wd; rd_addr_i = rd;
    if (gnt_dly >= 0) begin
      b.addr = {addr[31:2], 2'b00}; b.be = exp_be; b.wdata = exp_wd; b.we = we;
      bus_q.push_back(b);
      if (!we) begin
        e.is_err = 1'b0; e.rd = rd; e.data = exp_data;
        ev_q.push_back(e);
      end
    end else begin
      e.is_err = 1'b1; e.rd = 5'd0; e.data = 32'd0;
      ev_q.push_back(e);
    end
    #1 check_eq("hold_accept", 32'(hold_flag_o), 32'd1);
    @(posedge clk); #1 ls_valid_i = 1'b0;
    if (gnt_dly < 0) begin
      n = 0;
      while (!err_o && n < 40) begin
        @(negedge clk);
        n++;
      end
      check_eq("timeout_err_seen", 32'(err_o), 32'd1);
      check_eq("timeout_req_cycles", 32'(req_total - r0), 32'(TO));
      @(posedge clk); #1;
      check_eq("timeout_err_pulse", 32'(err_o), 32'd0);
      check_eq("timeout_idle_hold", 32'(hold_flag_o), 32'd0);
    end else begin
      repeat (gnt_dly) @(posedge clk);
      #1 mem_gnt_i = 1'b1;
      @(posedge clk); #1 mem_gnt_i = 1'b0;
      check_eq("req_dropped", 32'(mem_req_o), 32'd0);
      if (!we) begin
        check_eq("hold_wait", 32'(hold_flag_o), 32'd1);
        repeat (rv_dly) @(posedge clk);
        #1 mem_rvalid_i = 1'b1; mem_rdata_i = rdata;
        @(posedge clk); #1 mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;
      end
      check_eq("hold_done", 32'(hold_flag_o), 32'd0);
      check_eq("req_cycles", 32'(req_total - r0), 32'(gnt_dly + 1));
      @(negedge clk);
    end
  endtask

  task automatic illegal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    ev_t e;
    int  r0;
    r0 = req_total;
    @(posedge clk); #1;
    ls_valid_i = 1'b1; ls_we_i = we; ls_func3_i = f3;
    ls_addr_i = addr; ls_wdata_i = 32'h5555_AAAA; rd_addr_i = 5'd9;
    e.is_err = 1'b1; e.rd = 5'd0; e.data = 32'd0;
    ev_q.push_back(e);
    #1;
    check_eq("illegal_hold", 32'(hold_flag_o), 32'd0);
    check_eq("illegal_err_early", 32'(err_o), 32'd0);
    @(posedge clk); #1 ls_valid_i = 1'b0;
    check_eq("illegal_err", 32'(err_o), 32'd1);
    check_eq("illegal_req", 32'(mem_req_o), 32'd0);
    @(posedge clk); #1;
    check_eq("illegal_err_pulse", 32'(err_o), 32'd0);
    check_eq("illegal_no_req", 32'(req_total - r0), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_req"}, 32'(mem_req_o), 32'd0);
    check_eq({tag, "_we"}, 32'(mem_we_o), 32'd0);
    check_eq({tag, "_addr"}, mem_addr_o, 32'd0);
    check_eq({tag, "_be"}, 32'(mem_be_o), 32'd0);
    check_eq({tag, "_wdata"}, mem_wdata_o, 32'd0);
    check_eq({tag, "_rd_wen"}, 32'(rd_wen_o), 32'd0);
    check_eq({tag, "_rd_addr"}, 32'(rd_addr_o), 32'd0);
    check_eq({tag, "_rd_data"}, rd_data_o, 32'd0);
    check_eq({tag, "_hold"}, 32'(hold_flag_o), 32'd0);
    check_eq({tag, "_err"}, 32'(err_o), 32'd0);
  endtask

  initial begin
    bus_t b;
    ls_valid_i = 1'b0; ls_we_i = 1'b0; ls_func3_i = 3'd0; ls_addr_i = 32'd0;
    ls_wdata_i = 32'd0; rd_addr_i = 5'd0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;
    fork monitor(); join_none

    // A legal load presented during reset must not raise hold.
    #3 ls_valid_i = 1'b1; ls_func3_i = INST_LW; ls_addr_i = 32'h40;
    #10 check_all_zero("reset");
    ls_valid_i = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    access(1'b0, INST_LW, 32'h100, 32'h0, 5'd3, 2, 32'hDEAD_BEEF, 0,
           32'hDEAD_BEEF, 4'b1111, 32'h0);
    access(1'b0, INST_LB, 32'h103, 32'h0, 5'd4, 0, 32'h80FF_0000, 1,
           32'hFFFF_FF80, 4'b1000, 32'h0);
    access(1'b0, INST_LBU, 32'h103, 32'h0, 5'd5, 1, 32'h80FF_0000, 0,
           32'h0000_0080, 4'b1000, 32'h0);
    access(1'b1, INST_SH, 32'h202, 32'h1234_ABCD, 5'd6, 0, 32'h0, 0,
           32'h0, 4'b1100, 32'hABCD_ABCD);
    access(1'b0, INST_LH, 32'h206, 32'h0, 5'd8, 0, 32'h8001_7FFF, 0,
           32'hFFFF_8001, 4'b1100, 32'h0);
    access(1'b0, INST_LHU, 32'h204, 32'h0, 5'd10, 0, 32'h1234_F00D, 0,
           32'h0000_F00D, 4'b0011, 32'h0);
    access(1'b1, INST_SB, 32'h301, 32'hAABB_CC5A, 5'd1, 1, 32'h0, 0,
           32'h0, 4'b0010, 32'h5A5A_5A5A);

    illegal(1'b0, INST_LW, 32'h101);
    illegal(1'b1, INST_SH, 32'h003);
    illegal(1'b0, 3'b011, 32'h100);
    illegal(1'b1, INST_LBU, 32'h100);

    access(1'b0, INST_LW, 32'h400, 32'h0, 5'd12, -1, 32'h0, 0,
           32'h0, 4'b1111, 32'h0);

    // Reset asserted while a load waits for rvalid.
    @(posedge clk); #1;
    ls_valid_i = 1'b1; ls_we_i = 1'b0; ls_func3_i = INST_LW;
    ls_addr_i = 32'h300; rd_addr_i = 5'd7;
    b.addr = 32'h300; b.be = 4'b1111; b.wdata = 32'h0; b.we = 1'b0;
    bus_q.push_back(b);
    @(posedge clk); #1 ls_valid_i = 1'b0; mem_gnt_i = 1'b1;
    @(posedge clk); #1 mem_gnt_i = 1'b0;
    check_eq("rst_wait_hold", 32'(hold_flag_o), 32'd1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    access(1'b0, INST_LW, 32'h304, 32'h0, 5'd7, 1, 32'h0BAD_F00D, 1,
           32'h0BAD_F00D, 4'b1111, 32'h0);

    for (int i = 0; i < 10; i++) begin
      logic        we;
      logic [2:0]  f3;
      logic [1:0]  off;
      logic [31:0] a, wd, rdv;
      logic [4:0]  rd;
      we = 1'(($urandom_range(0, 1)));
      case ($urandom_range(0, we ? 2 : 4))
        0: f3 = INST_LB;
        1: f3 = INST_LH;
        2: f3 = INST_LW;
        3: f3 = INST_LBU;
        default: f3 = INST_LHU;
      endcase
      off = 2'($urandom_range(0, 3));
      if (f3[1:0] == 2'b01) off[0] = 1'b0;
      if (f3[1:0] == 2'b10) off = 2'b00;
      a = 32'h1000 + 32'($urandom_range(0, 63) * 4) + 32'(off);
      wd = $urandom;
      rdv = $urandom;
      rd = 5'($urandom_range(1, 31));
      access(we, f3, a, wd, rd, $urandom_range(0, 3), rdv, $urandom_range(0, 2),
             m_load(f3, off, rdv), m_be(f3, off), m_wdata(f3, wd));
    end

    repeat (3) @(posedge clk);
    #1;
    check_eq("bus_queue_drained", 32'(bus_q.size()), 32'd0);
    check_eq("event_queue_drained", 32'(ev_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
